// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue path: op encodings, controller states, counter width.
// Pure declarations; no latency or backpressure of its own.
package mul_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic logic op_is_rsvd(input logic [1:0] op);
        return op == MUL_OP_RSVD;
    endfunction

endpackage

// File: rtl/mul_result_cache.sv
// One-entry memo of the last completed multiply keyed on {rs1, rs2, op}; hit/data are combinational from cmp_*.
// Write takes effect at the next edge; no handshake, the controller decides when to write and when to ask.
module mul_result_cache
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_a_i,
    input  logic [XLEN-1:0] wr_b_i,
    input  logic [1:0]      wr_op_i,
    input  logic [XLEN-1:0] wr_result_i,
    input  logic [XLEN-1:0] cmp_a_i,
    input  logic [XLEN-1:0] cmp_b_i,
    input  logic [1:0]      cmp_op_i,
    output logic            hit_o,
    output logic [XLEN-1:0] data_o
);

    logic            valid_q;
    logic [XLEN-1:0] key_a_q;
    logic [XLEN-1:0] key_b_q;
    logic [1:0]      key_op_q;
    logic [XLEN-1:0] data_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            key_a_q  <= '0;
            key_b_q  <= '0;
            key_op_q <= MUL_OP_MUL;
            data_q   <= '0;
        end else if (wr_en_i) begin
            valid_q  <= 1'b1;
            key_a_q  <= wr_a_i;
            key_b_q  <= wr_b_i;
            key_op_q <= wr_op_i;
            data_q   <= wr_result_i;
        end
    end

    // Op is part of the key so MUL and MULH of the same operands never alias.
    assign hit_o  = valid_q && (key_a_q == cmp_a_i) && (key_b_q == cmp_b_i) && (key_op_q == cmp_op_i);
    assign data_o = data_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues one multiply at a time to an external LATENCY-cycle multiplier; miss result after LATENCY+1 cycles, cache hit or reserved op after 1.
// Holds result/tag in DONE until out_ready_i; accepts only in IDLE, flush_i kills everything and wins over both handshakes.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [XLEN-1:0]  in_rs1_i,
    input  logic [XLEN-1:0]  in_rs2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [XLEN-1:0]  mul_a_o,
    output logic [XLEN-1:0]  mul_b_o,
    output logic [1:0]       mul_op_o,
    output logic             mul_en_o,
    input  logic [XLEN-1:0]  mul_product_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic             mul_en_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  result_q;
    logic [XLEN-1:0]  result_d;

    logic             accept;
    logic             capture;
    logic             cache_wr;
    logic             cache_hit;
    logic [XLEN-1:0]  cache_data;

    assign in_ready_o = (state_q == IDLE) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign capture    = (state_q == BUSY) && (cnt_q == CNT_LAST);
    assign cache_wr   = capture && !flush_i;

    // Lookup uses the incoming operands so a hit can land in DONE on the accept edge itself.
    mul_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .wr_en_i     (cache_wr),
        .wr_a_i      (a_q),
        .wr_b_i      (b_q),
        .wr_op_i     (op_q),
        .wr_result_i (mul_product_i),
        .cmp_a_i     (in_rs1_i),
        .cmp_b_i     (in_rs2_i),
        .cmp_op_i    (in_op_i),
        .hit_o       (cache_hit),
        .data_o      (cache_data)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            mul_en_q    <= 1'b0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            mul_en_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        if (op_is_rsvd(in_op_i) || cache_hit) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q  <= BUSY;
                            cnt_q    <= '0;
                            mul_en_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (capture) begin
                        state_q     <= DONE;
                        mul_en_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    mul_en_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        result_d = result_q;
        if (accept) begin
            if (op_is_rsvd(in_op_i)) begin
                result_d = '0;
            end else if (cache_hit) begin
                result_d = cache_data;
            end
        end
        if (cache_wr) begin
            result_d = mul_product_i;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= MUL_OP_MUL;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= in_rs1_i;
                b_q   <= in_rs2_i;
                op_q  <= in_op_i;
                tag_q <= in_tag_i;
            end
            result_q <= result_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_result_o = result_q;
    assign out_tag_o    = tag_q;
    assign mul_a_o      = a_q;
    assign mul_b_o      = b_q;
    assign mul_op_o     = op_q;
    assign mul_en_o     = mul_en_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: vector table plus scoreboard on a LATENCY=2 instance, flush corner on a LATENCY=3 instance.
// The multiplier stub returns garbage until enable has been high for LATENCY cycles.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, mul_en;
    logic [1:0]  in_op = 2'b00, mul_op;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, out_result, mul_a, mul_b, mul_product;
    logic [4:0]  in_tag = '0, out_tag;

    logic        d3_flush = 1'b0, d3_in_valid = 1'b0, d3_out_ready = 1'b1;
    logic        d3_in_ready, d3_out_valid, d3_mul_en;
    logic [1:0]  d3_in_op = 2'b00, d3_mul_op;
    logic [31:0] d3_in_rs1 = '0, d3_in_rs2 = '0, d3_out_result, d3_mul_a, d3_mul_b, d3_mul_product;
    logic [4:0]  d3_in_tag = '0, d3_out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  tag;
        bit          fast;
    } vec_t;
    vec_t vecs[11];

    always #5 CLK = ~CLK;

    mul_issue_ctrl #(.XLEN(32), .LATENCY(2), .TAG_W(5)) u_dut (
        .CLK (CLK), .rst_n (rst_n), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready), .in_op_i (in_op),
        .in_rs1_i (in_rs1), .in_rs2_i (in_rs2), .in_tag_i (in_tag),
        .out_valid_o (out_valid), .out_ready_i (out_ready),
        .out_result_o (out_result), .out_tag_o (out_tag),
        .mul_a_o (mul_a), .mul_b_o (mul_b), .mul_op_o (mul_op),
        .mul_en_o (mul_en), .mul_product_i (mul_product)
    );

    mul_issue_ctrl #(.XLEN(32), .LATENCY(3), .TAG_W(5)) u_dut3 (
        .CLK (CLK), .rst_n (rst_n), .flush_i (d3_flush),
        .in_valid_i (d3_in_valid), .in_ready_o (d3_in_ready), .in_op_i (d3_in_op),
        .in_rs1_i (d3_in_rs1), .in_rs2_i (d3_in_rs2), .in_tag_i (d3_in_tag),
        .out_valid_o (d3_out_valid), .out_ready_i (d3_out_ready),
        .out_result_o (d3_out_result), .out_tag_o (d3_out_tag),
        .mul_a_o (d3_mul_a), .mul_b_o (d3_mul_b), .mul_op_o (d3_mul_op),
        .mul_en_o (d3_mul_en), .mul_product_i (d3_mul_product)
    );

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (op)
            2'b00:   p = {32'b0, a} * ub;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = '0;
        endcase
        return (op == 2'b00) ? p[31:0] : (op == 2'b11) ? 32'h0 : p[63:32];
    endfunction

    int en_run;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) en_run <= 0;
        else        en_run <= mul_en ? en_run + 1 : 0;
    end

    always_comb begin
        mul_product = 32'hDEADBEEF;
        if (mul_en && (en_run + 1 >= 2)) mul_product = ref_mul(mul_op, mul_a, mul_b);
        d3_mul_product = ref_mul(d3_mul_op, d3_mul_a, d3_mul_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: one entry consumed per output handshake.
    always @(negedge CLK) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result 0x%08h with empty queue", out_result);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_result", out_result, e.res);
                check("sb_tag", {27'b0, out_tag}, {27'b0, e.tag});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit fast, input int hold);
        int n, lat, en;
        logic [31:0] r0;
        logic [4:0]  t0;
        sb_t e;
        @(negedge CLK);
        out_ready = (hold == 0);
        in_op = op; in_rs1 = a; in_rs2 = b; in_tag = t; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge CLK); n++; end
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        @(posedge CLK); #1 in_valid = 1'b0;
        e.res = ref_mul(op, a, b);
        e.tag = t;
        sb_q.push_back(e);
        lat = 0; en = 0;
        do begin
            @(negedge CLK); lat++;
            if (mul_en) en++;
        end while (!out_valid && lat < 40);
        check("latency", lat, fast ? 32'd1 : 32'd3);
        check("en_cycles", en, fast ? 32'd0 : 32'd2);
        if (hold > 0) begin
            r0 = out_result; t0 = out_tag;
            for (int k = 0; k < hold; k++) begin
                @(posedge CLK); @(negedge CLK);
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_result", out_result, r0);
                check("hold_tag", {27'b0, out_tag}, {27'b0, t0});
                check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            end
            @(posedge CLK); #1 out_ready = 1'b1;
            @(negedge CLK);
        end
        @(posedge CLK);
        if (hold > 0) begin
            @(negedge CLK);
            check("ready_after_hs", {31'b0, in_ready}, 32'd1);
            check("valid_after_hs", {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en;
        bit seen;
        vecs[0]  = '{MUL_OP_MUL,    32'd7,          32'd6,          5'd3,  1'b0};
        vecs[1]  = '{MUL_OP_MUL,    32'd7,          32'd6,          5'd4,  1'b1};
        vecs[2]  = '{MUL_OP_MULH,   32'd7,          32'd6,          5'd5,  1'b0};
        vecs[3]  = '{MUL_OP_MULH,   32'h8000_0000,  32'd2,          5'd6,  1'b0};
        vecs[4]  = '{MUL_OP_MULHSU, 32'h8000_0000,  32'd2,          5'd7,  1'b0};
        vecs[5]  = '{MUL_OP_RSVD,   32'd7,          32'd6,          5'd8,  1'b1};
        vecs[6]  = '{MUL_OP_MULHSU, 32'h8000_0000,  32'd2,          5'd9,  1'b1};
        vecs[7]  = '{MUL_OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 1'b0};
        vecs[8]  = '{MUL_OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 1'b0};
        vecs[9]  = '{MUL_OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd11, 1'b0};
        vecs[10] = '{MUL_OP_MUL,    32'd7,          32'd6,          5'd0,  1'b0};

        repeat (3) @(negedge CLK);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_tag", {27'b0, out_tag}, 32'd0);
        check("rst_mul_en", {31'b0, mul_en}, 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_mul_op", {30'b0, mul_op}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].tag, vecs[i].fast, 0);

        issue(MUL_OP_MUL, 32'd3, 32'd5, 5'd12, 1'b0, 5);

        // Flush during the capture cycle must leave the cache untouched.
        @(negedge CLK);
        in_op = MUL_OP_MUL; in_rs1 = 32'd11; in_rs2 = 32'd13; in_tag = 5'd13; in_valid = 1'b1;
        @(posedge CLK); #1 in_valid = 1'b0;
        @(posedge CLK); #1 flush = 1'b1;
        @(posedge CLK); #1 flush = 1'b0;
        @(negedge CLK);
        check("flushcap_valid", {31'b0, out_valid}, 32'd0);
        check("flushcap_ready", {31'b0, in_ready}, 32'd1);
        check("flushcap_en", {31'b0, mul_en}, 32'd0);
        issue(MUL_OP_MUL, 32'd11, 32'd13, 5'd13, 1'b0, 0);

        // LATENCY=3 instance: flush in the second BUSY cycle.
        @(negedge CLK);
        check("d3_ready0", {31'b0, d3_in_ready}, 32'd1);
        d3_in_op = MUL_OP_MUL; d3_in_rs1 = 32'd9; d3_in_rs2 = 32'd9; d3_in_tag = 5'd2; d3_in_valid = 1'b1;
        @(posedge CLK); #1 d3_in_valid = 1'b0;
        @(posedge CLK); #1 d3_flush = 1'b1;
        @(negedge CLK);
        check("d3_flush_masks_ready", {31'b0, d3_in_ready}, 32'd0);
        check("d3_busy_en", {31'b0, d3_mul_en}, 32'd1);
        @(posedge CLK); #1 d3_flush = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge CLK); if (d3_out_valid) seen = 1'b1; end
        check("d3_no_valid", {31'b0, seen}, 32'd0);
        check("d3_idle_en", {31'b0, d3_mul_en}, 32'd0);
        check("d3_idle_ready", {31'b0, d3_in_ready}, 32'd1);
        d3_in_valid = 1'b1;
        @(posedge CLK); #1 d3_in_valid = 1'b0;
        lat = 0; en = 0;
        do begin
            @(negedge CLK); lat++;
            if (d3_mul_en) en++;
        end while (!d3_out_valid && lat < 40);
        check("d3_reissue_latency", lat, 32'd4);
        check("d3_reissue_en", en, 32'd3);
        check("d3_result", d3_out_result, 32'd81);
        check("d3_tag", {27'b0, d3_out_tag}, 32'd2);
        @(posedge CLK);

        // Asynchronous reset mid-BUSY clears outputs and the cache.
        issue(MUL_OP_MUL, 32'd4, 32'd4, 5'd1, 1'b0, 0);
        @(negedge CLK);
        in_op = MUL_OP_MUL; in_rs1 = 32'd5; in_rs2 = 32'd5; in_tag = 5'd14; in_valid = 1'b1;
        @(posedge CLK); #1 in_valid = 1'b0;
        @(negedge CLK);
        check("pre_rst_en", {31'b0, mul_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_result", out_result, 32'd0);
        check("arst_tag", {27'b0, out_tag}, 32'd0);
        check("arst_mul_en", {31'b0, mul_en}, 32'd0);
        check("arst_mul_a", mul_a, 32'd0);
        check("arst_mul_b", mul_b, 32'd0);
        check("arst_mul_op", {30'b0, mul_op}, 32'd0);
        @(negedge CLK); rst_n = 1'b1;
        issue(MUL_OP_MUL, 32'd4, 32'd4, 5'd1, 1'b0, 0);

        @(negedge CLK);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
